mpu_reg_arbiter: RTL and testbench

Arbitrates the matrix register file's shared access port among four requesters: load, store, dispatcher and collector. Exactly one requester holds the port at a time. The arbiter issues a one-hot registered grant, holds it until the owner drops its request, and rotates priority round-robin so no requester starves. It sits between those four blocks and `mpu_register_file`, and gates their `reg_*_req` strobes.

---
 rtl/mpu_reg_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_mpu_reg_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mpu_reg_arbiter.sv
// mpu_reg_arbiter
//
// Shares the matrix register file access port among four requesters.
// Only one requester owns the port at a time. The grant is one-hot and
// registered. It is held until the owner drops its request. Priority
// rotates round-robin and advances past each owner on release.
//
// Optional feature: define MPU_ARB_TIMEOUT_EN to compile in the grant
// watchdog. The watchdog forcibly releases an owner after MAX_HOLD
// consecutive grant cycles. The revoked requester is then masked until it
// drops its request. Without the macro there is no counter and no mask,
// and timeout_out/timeout_id_out are tied to 0.
//
// Parameters:
//   MAX_HOLD        max consecutive grant cycles (watchdog only), 2..255
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous reset, active high
//   req_in[3:0]     requests: 0 load, 1 store, 2 dispatcher, 3 collector
//   grant_out[3:0]  registered one-hot grant, 0 when the port is free
//   grant_id_out    index of current owner (meaningful while busy_out)
//   busy_out        port owned
//   timeout_out     sticky: a forced release has happened
//   timeout_id_out  index of the requester last forcibly released

module mpu_reg_arbiter #(
   parameter int unsigned MAX_HOLD = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req_in,
   output logic [3:0] grant_out,
   output logic [1:0] grant_id_out,
   output logic       busy_out,
   output logic       timeout_out,
   output logic [1:0] timeout_id_out
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] ptr, ptr_nxt;
   logic [3:0] grant_q, grant_nxt;
   logic [1:0] gid_q, gid_nxt;
   logic       busy_q, busy_nxt;

   logic [3:0] elig;
   logic       win_vld;
   logic [1:0] win_id;

   // Out-of-range MAX_HOLD leaves this marker block in the elaborated
   // hierarchy. The 8-bit hold counter cannot represent larger values.
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_out_of_range
   end

`ifdef MPU_ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_cnt, hold_cnt_nxt;
   logic [3:0] mask_q, mask_nxt;
   logic       to_q, to_nxt;
   logic [1:0] tid_q, tid_nxt;
   logic       hold_expired;

   assign hold_expired = (hold_cnt == HOLD_LAST);
   // A revoked requester stays out of arbitration until it lets go.
   assign elig         = req_in & ~mask_q;
`else
   assign elig         = req_in;
`endif

   // Round-robin pick starting at ptr. The scan runs from the farthest
   // offset to the nearest, so the nearest eligible requester is written
   // last and wins.
   always_comb begin
      win_vld = 1'b0;
      win_id  = ptr;
      for (int k = 3; k >= 0; k--) begin
         if (elig[ptr + 2'(k)]) begin
            win_vld = 1'b1;
            win_id  = ptr + 2'(k);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      grant_nxt = grant_q;
      gid_nxt   = gid_q;
      busy_nxt  = busy_q;
`ifdef MPU_ARB_TIMEOUT_EN
      hold_cnt_nxt = hold_cnt;
      mask_nxt     = mask_q & req_in;  // a low request clears its mask bit
      to_nxt       = to_q;
      tid_nxt      = tid_q;
`endif
      case (state)
         S_IDLE: begin
            if (win_vld) begin
               grant_nxt = 4'(1) << win_id;
               gid_nxt   = win_id;
               busy_nxt  = 1'b1;
               state_nxt = S_GRANT;
`ifdef MPU_ARB_TIMEOUT_EN
               hold_cnt_nxt = 8'd0;
`endif
            end
         end
         S_GRANT: begin
            // Only the owner's bit matters here. Other requesters wait for
            // the next arbitration.
            if (!req_in[gid_q]) begin
               grant_nxt = 4'b0000;
               busy_nxt  = 1'b0;
               ptr_nxt   = gid_q + 2'd1;
               state_nxt = S_RELEASE;
            end
`ifdef MPU_ARB_TIMEOUT_EN
            else if (hold_expired) begin
               grant_nxt        = 4'b0000;
               busy_nxt         = 1'b0;
               ptr_nxt          = gid_q + 2'd1;
               state_nxt        = S_RELEASE;
               to_nxt           = 1'b1;
               tid_nxt          = gid_q;
               mask_nxt[gid_q]  = 1'b1;
            end
            else begin
               hold_cnt_nxt = hold_cnt + 8'd1;
            end
`endif
         end
         S_RELEASE: begin
            // Bubble cycle. Arbitration resumes in IDLE.
            state_nxt = S_IDLE;
         end
         default: begin
            grant_nxt = 4'b0000;
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         ptr     <= 2'd0;
         grant_q <= 4'b0000;
         gid_q   <= 2'd0;
         busy_q  <= 1'b0;
`ifdef MPU_ARB_TIMEOUT_EN
         hold_cnt <= 8'd0;
         mask_q   <= 4'b0000;
         to_q     <= 1'b0;
         tid_q    <= 2'd0;
`endif
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         grant_q <= grant_nxt;
         gid_q   <= gid_nxt;
         busy_q  <= busy_nxt;
`ifdef MPU_ARB_TIMEOUT_EN
         hold_cnt <= hold_cnt_nxt;
         mask_q   <= mask_nxt;
         to_q     <= to_nxt;
         tid_q    <= tid_nxt;
`endif
      end
   end

   assign grant_out    = grant_q;
   assign grant_id_out = gid_q;
   assign busy_out     = busy_q;
`ifdef MPU_ARB_TIMEOUT_EN
   assign timeout_out    = to_q;
   assign timeout_id_out = tid_q;
`else
   assign timeout_out    = 1'b0;
   assign timeout_id_out = 2'd0;
`endif

endmodule

// File: tb/tb_mpu_reg_arbiter.sv
// Directed bench for mpu_reg_arbiter. It checks the reset state, grant
// latency and tenure, round-robin order with wrap, reset mid-grant, and
// either the watchdog (MPU_ARB_TIMEOUT_EN) or indefinite hold.
module tb_mpu_reg_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_in;
   logic [3:0] grant_out;
   logic [1:0] grant_id_out;
   logic       busy_out;
   logic       timeout_out;
   logic [1:0] timeout_id_out;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mpu_reg_arbiter #(.MAX_HOLD(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_in         (req_in),
      .grant_out      (grant_out),
      .grant_id_out   (grant_id_out),
      .busy_out       (busy_out),
      .timeout_out    (timeout_out),
      .timeout_id_out (timeout_id_out)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Advance one clock; inputs and samples sit 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      req_in = 4'b0000;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // ---- reset state ----
      do_reset();
      chk("rst_grant", {4'h0, grant_out}, 8'h00);
      chk("rst_gid",   {6'h0, grant_id_out}, 8'h00);
      chk("rst_busy",  {7'h0, busy_out}, 8'h00);
      chk("rst_to",    {7'h0, timeout_out}, 8'h00);
      chk("rst_tid",   {6'h0, timeout_id_out}, 8'h00);

      // ---- single load burst of 3 cycles ----
      req_in = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("load_grant%0d", i), {4'h0, grant_out}, 8'h01);
         chk($sformatf("load_busy%0d", i), {7'h0, busy_out}, 8'h01);
      end
      chk("load_gid", {6'h0, grant_id_out}, 8'h00);
      req_in = 4'b0000;
      tick();
      chk("load_rel_grant", {4'h0, grant_out}, 8'h00);
      chk("load_rel_busy",  {7'h0, busy_out}, 8'h00);
      tick();  // RELEASE -> IDLE
      // ptr is now 1, so store beats load.
      req_in = 4'b0011;
      tick();
      chk("ptr1_store_wins", {4'h0, grant_out}, 8'h02);
      chk("ptr1_gid",        {6'h0, grant_id_out}, 8'h01);

      // ---- full rotation from reset with all four requesting ----
      do_reset();
      req_in = 4'b1111;
      tick();
      for (int i = 0; i < 4; i++) begin
         logic [3:0] exp_g;
         exp_g = 4'(1) << i;
         chk($sformatf("rr_grant%0d", i), {4'h0, grant_out}, {4'h0, exp_g});
         chk($sformatf("rr_gid%0d", i), {6'h0, grant_id_out}, 8'(i));
         tick();
         chk($sformatf("rr_hold%0d", i), {4'h0, grant_out}, {4'h0, exp_g});
         req_in = req_in & ~exp_g;
         tick();
         chk($sformatf("rr_gap_a%0d", i), {4'h0, grant_out}, 8'h00);
         tick();
         chk($sformatf("rr_gap_b%0d", i), {4'h0, grant_out}, 8'h00);
         if (i < 3) tick();
      end

      // ---- wrap-around: collector released, ptr is 0 ----
      req_in = 4'b1001;
      tick();
      chk("wrap_load_wins", {4'h0, grant_out}, 8'h01);
      req_in = 4'b0000;
      tick();
      tick();

      // ---- reset while the dispatcher owns the port ----
      do_reset();
      req_in = 4'b0100;
      tick();
      chk("pre_rst_grant", {4'h0, grant_out}, 8'h04);
      rst = 1'b1;
      tick();
      chk("midrst_grant", {4'h0, grant_out}, 8'h00);
      chk("midrst_busy",  {7'h0, busy_out}, 8'h00);
      chk("midrst_gid",   {6'h0, grant_id_out}, 8'h00);
      rst    = 1'b0;
      req_in = 4'b0110;
      tick();
      chk("postrst_store", {4'h0, grant_out}, 8'h02);
      req_in = 4'b0000;
      tick();
      tick();

      // ---- dispatcher holds continuously, store pending ----
      do_reset();
      req_in = 4'b0100;
      tick();
      chk("hog_grant0", {4'h0, grant_out}, 8'h04);
      req_in = 4'b0110;
`ifdef MPU_ARB_TIMEOUT_EN
      for (int i = 1; i < 8; i++) begin
         tick();
         chk($sformatf("hog_hold%0d", i), {4'h0, grant_out}, 8'h04);
      end
      chk("hog_to_before", {7'h0, timeout_out}, 8'h00);
      tick();
      chk("revoke_grant", {4'h0, grant_out}, 8'h00);
      chk("revoke_to",    {7'h0, timeout_out}, 8'h01);
      chk("revoke_tid",   {6'h0, timeout_id_out}, 8'h02);
      tick();
      chk("revoke_gap", {4'h0, grant_out}, 8'h00);
      tick();
      chk("revoke_store", {4'h0, grant_out}, 8'h02);
      // Store leaves; the dispatcher is still masked and gets nothing.
      req_in = 4'b0100;
      tick();
      tick();
      tick();
      tick();
      chk("mask_blocks", {4'h0, grant_out}, 8'h00);
      chk("to_sticky",   {7'h0, timeout_out}, 8'h01);
      // Dropping the request for a cycle clears the mask.
      req_in = 4'b0000;
      tick();
      req_in = 4'b0100;
      tick();
      tick();
      chk("unmask_grant", {4'h0, grant_out}, 8'h04);
`else
      for (int i = 1; i < 120; i++) begin
         tick();
         chk($sformatf("hog_hold%0d", i), {4'h0, grant_out}, 8'h04);
      end
      chk("hog_to",  {7'h0, timeout_out}, 8'h00);
      chk("hog_tid", {6'h0, timeout_id_out}, 8'h00);
`endif
      req_in = 4'b0000;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
